vga_scan: RTL and testbench
===========================

VGA_SCAN -- requirements
Module: vga_scan

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 SHALL have parameter H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync widths in pixels.
REQ-004 SHALL have parameter V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 SHALL have port clk_25mhz, input, 1, pixel clock; the only clock.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port en, input, 1, display enable; 0 forces black, timing keeps running.
REQ-009 SHALL have port vram_scan_addr, output, 20, linear pixel address into video memory.
REQ-010 SHALL have port vram_scan_data, input, 16, RGB565 pixel; valid one clk_25mhz cycle after vram_scan_addr.
REQ-011 SHALL have port hsync, output, 1, horizontal sync, active low.
REQ-012 SHALL have port vsync, output, 1, vertical sync, active low.
REQ-013 SHALL have ports vga_r, vga_g, vga_b, output, 4 each, pixel colour.
REQ-014 SHALL have port frame_start, output, 1, one-cycle pulse at h=0, v=0.

Function
REQ-015 SHALL keep h_cnt 0..799 and v_cnt 0..524; h_cnt wraps to 0 after 799; v_cnt increments on each h wrap and wraps to 0 after 524.
REQ-016 SHALL derive totals from parameters: H_TOTAL = sum of H params, V_TOTAL = sum of V params.
REQ-017 SHALL treat a pixel as active when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-018 SHALL compute raw hsync low for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; raw vsync likewise.
REQ-019 SHALL register vram_scan_addr = v_cnt*H_ACTIVE + h_cnt for active pixels, built incrementally (no multiplier): +1 per active pixel, held during blanking, 0 at frame start.
REQ-020 SHALL keep vram_scan_addr below H_ACTIVE*V_ACTIVE (307200); last active pixel addresses 307199.
REQ-021 SHALL have total pixel latency of 2 cycles: counters -> registered address (1) -> vram_scan_data (1).
REQ-022 SHALL delay active, raw hsync and raw vsync through a 2-stage shift register so outputs align with vram_scan_data.
REQ-023 SHALL map RGB565 to outputs: vga_r = data[15:12], vga_g = data[10:7], vga_b = data[4:1], all registered.
REQ-024 SHALL output RGB = 0 when the delayed active flag is 0 or en is 0.
REQ-025 SHALL assert frame_start for exactly one cycle when counters are (0,0), undelayed.
REQ-026 SHALL clear the address at frame start when en toggles mid-frame; the next frame is correct regardless of en history.

Reset
REQ-027 SHALL on rst asynchronously set h_cnt=0, v_cnt=0, vram_scan_addr=0, hsync=1, vsync=1, RGB=0, frame_start=0, delay pipeline cleared.
REQ-028 SHALL start counting on the first clk_25mhz edge after rst deasserts; reset mid-frame restarts at (0,0).

Structure
REQ-029 SHALL place timing constants (640/16/96/48, 480/10/2/33, totals, frame size 307200) in shared package vga_pkg.
REQ-030 SHALL split counter/sync generation into sub-module vga_timing (outputs h_cnt, v_cnt, active, raw syncs); vga_scan adds addressing, alignment and colour.

Verification
REQ-031 SHALL check reset release: after rst, hsync=1, vsync=1, RGB=0, frame_start pulses on the first edge, then every 420000 cycles.
REQ-032 SHALL check line timing: hsync low exactly 96 cycles, falling edge 2+656 cycles after line start; line period 800.
REQ-033 SHALL check frame timing: vsync low exactly 2 lines (1600 cycles) starting at line 490; frame period 525 lines.
REQ-034 SHALL check addressing: addr = 0 at (0,0), 639 at (639,0), 640 at (0,1), 307199 at (639,479), held 307199 through blanking, 0 at next frame.
REQ-035 SHALL check data path: memory model returns data = 16'hF81F registered one cycle after address -> vga_r=F, vga_g=0, vga_b=F on active pixels; 0 in blanking.
REQ-036 SHALL check en and reset mid-frame: en=0 for lines 100..200 gives RGB=0 with syncs unchanged; rst at (300,250) gives outputs at reset values and restart from (0,0).

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 timing constants and scan control types
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF    = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF    = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int FRAME_SIZE_DEF = H_ACTIVE_DEF * V_ACTIVE_DEF;

    localparam int CNT_W  = 12;
    localparam int ADDR_W = 20;
    localparam int PIX_W  = 16;
    localparam int RGB_W  = 4;

    // Syncs are carried active-low, exactly as they leave the chip.
    typedef struct packed {
        logic active;
        logic hsync_n;
        logic vsync_n;
    } scan_ctl_t;

    localparam scan_ctl_t CTL_IDLE = '{active: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1};

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - horizontal/vertical counters with raw active and sync flags
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic [CNT_W-1:0] o_h_cnt,
    output logic [CNT_W-1:0] o_v_cnt,
    output logic             o_h_wrap,
    output logic             o_v_wrap,
    output scan_ctl_t        o_ctl
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] L_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] L_H_ACT   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] L_H_SS    = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] L_H_SE    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] L_H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] L_V_ACT   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] L_V_SS    = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] L_V_SE    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] L_V_LAST  = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic             w_h_wrap;
    logic             w_v_wrap;

    assign w_h_wrap = (r_h_cnt == L_H_LAST);
    assign w_v_wrap = (r_v_cnt == L_V_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_wrap) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + L_ONE;
        end else begin
            r_h_cnt <= r_h_cnt + L_ONE;
        end
    end

    assign o_h_cnt  = r_h_cnt;
    assign o_v_cnt  = r_v_cnt;
    assign o_h_wrap = w_h_wrap;
    assign o_v_wrap = w_v_wrap;

    always_comb begin
        o_ctl         = CTL_IDLE;
        o_ctl.active  = (r_h_cnt < L_H_ACT) && (r_v_cnt < L_V_ACT);
        o_ctl.hsync_n = !((r_h_cnt >= L_H_SS) && (r_h_cnt < L_H_SE));
        o_ctl.vsync_n = !((r_v_cnt >= L_V_SS) && (r_v_cnt < L_V_SE));
    end

endmodule

// File: rtl/vga_scan.sv
// rtl/vga_scan.sv - VGA scan-out: timing, incremental VRAM addressing, sync/colour alignment
module vga_scan
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic              clk_25mhz,
    input  logic              rst,
    input  logic              en,
    output logic [ADDR_W-1:0] vram_scan_addr,
    input  logic [PIX_W-1:0]  vram_scan_data,
    output logic              hsync,
    output logic              vsync,
    output logic [RGB_W-1:0]  vga_r,
    output logic [RGB_W-1:0]  vga_g,
    output logic [RGB_W-1:0]  vga_b,
    output logic              frame_start
);

    localparam logic [CNT_W-1:0]  L_H_PRE  = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0]  L_V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0]  L_V_PRE  = CNT_W'(V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] L_A_ONE  = ADDR_W'(1);

    logic [CNT_W-1:0] w_h_cnt;
    logic [CNT_W-1:0] w_v_cnt;
    logic             w_h_wrap;
    logic             w_v_wrap;
    scan_ctl_t        w_ctl;
    logic             w_next_active;
    logic             w_frame_end;
    logic             w_unused_bits;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .i_clk    (clk_25mhz),
        .i_rst    (rst),
        .o_h_cnt  (w_h_cnt),
        .o_v_cnt  (w_v_cnt),
        .o_h_wrap (w_h_wrap),
        .o_v_wrap (w_v_wrap),
        .o_ctl    (w_ctl)
    );

    // The address register tracks the counters in the same cycle, so it
    // looks one position ahead: step when the next position is visible.
    assign w_next_active = w_h_wrap ? (!w_v_wrap && (w_v_cnt < L_V_PRE))
                                    : ((w_h_cnt < L_H_PRE) && (w_v_cnt < L_V_ACT));
    assign w_frame_end   = w_h_wrap && w_v_wrap;

    logic [ADDR_W-1:0] r_addr;
    logic              r_frame_start;
    scan_ctl_t         r_ctl_d1;
    logic              r_hsync_d2;
    logic              r_vsync_d2;
    logic [RGB_W-1:0]  r_r;
    logic [RGB_W-1:0]  r_g;
    logic [RGB_W-1:0]  r_b;

    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
        end else if (w_frame_end) begin
            r_addr <= '0;
        end else if (w_next_active) begin
            r_addr <= r_addr + L_A_ONE;
        end
    end

    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= (w_h_cnt == '0) && (w_v_cnt == '0);
        end
    end

    // Stage 1 lines up with vram_scan_data; the colour registers and the
    // second sync stage together form stage 2.
    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            r_ctl_d1   <= CTL_IDLE;
            r_hsync_d2 <= 1'b1;
            r_vsync_d2 <= 1'b1;
            r_r        <= '0;
            r_g        <= '0;
            r_b        <= '0;
        end else begin
            r_ctl_d1   <= w_ctl;
            r_hsync_d2 <= r_ctl_d1.hsync_n;
            r_vsync_d2 <= r_ctl_d1.vsync_n;
            if (r_ctl_d1.active && en) begin
                r_r <= vram_scan_data[15:12];
                r_g <= vram_scan_data[10:7];
                r_b <= vram_scan_data[4:1];
            end else begin
                r_r <= '0;
                r_g <= '0;
                r_b <= '0;
            end
        end
    end

    assign w_unused_bits  = ^{vram_scan_data[11], vram_scan_data[6:5], vram_scan_data[0]};

    assign vram_scan_addr = r_addr;
    assign frame_start    = r_frame_start;
    assign hsync          = r_hsync_d2;
    assign vsync          = r_vsync_d2;
    assign vga_r          = r_r;
    assign vga_g          = r_g;
    assign vga_b          = r_b;

endmodule

// File: tb/tb_vga_scan.sv
// tb/tb_vga_scan.sv - directed bench: 640x480 instance plus a scaled instance for frame-level behaviour
module tb_vga_scan;

    localparam int S_HA = 16;
    localparam int S_HF = 2;
    localparam int S_HS = 4;
    localparam int S_HB = 3;
    localparam int S_VA = 12;
    localparam int S_VF = 2;
    localparam int S_VS = 2;
    localparam int S_VB = 3;
    localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
    localparam int S_FRAME = S_HT * S_VT;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst_s;
    logic        en_d;
    logic        en_s;
    logic [19:0] addr_d, addr_s;
    logic [15:0] data_d = 16'h0, data_s = 16'h0;
    logic        hsync_d, vsync_d, hsync_s, vsync_s;
    logic [3:0]  r_d, g_d, b_d, r_s, g_s, b_s;
    logic        fs_d, fs_s;
    logic [11:0] rgb_d, rgb_s;

    int n_vec  = 0;
    int n_miss = 0;

    always #20 clk = ~clk;

    vga_scan u_dut_d (
        .clk_25mhz      (clk),
        .rst            (rst),
        .en             (en_d),
        .vram_scan_addr (addr_d),
        .vram_scan_data (data_d),
        .hsync          (hsync_d),
        .vsync          (vsync_d),
        .vga_r          (r_d),
        .vga_g          (g_d),
        .vga_b          (b_d),
        .frame_start    (fs_d)
    );

    vga_scan #(
        .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
        .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB)
    ) u_dut_s (
        .clk_25mhz      (clk),
        .rst            (rst_s),
        .en             (en_s),
        .vram_scan_addr (addr_s),
        .vram_scan_data (data_s),
        .hsync          (hsync_s),
        .vsync          (vsync_s),
        .vga_r          (r_s),
        .vga_g          (g_s),
        .vga_b          (b_s),
        .frame_start    (fs_s)
    );

    assign rgb_d = {r_d, g_d, b_d};
    assign rgb_s = {r_s, g_s, b_s};

    always @(posedge clk) data_d <= 16'hF81F;
    always @(posedge clk) data_s <= {addr_s[3:0], 1'b0, addr_s[7:4], 2'b00, addr_s[11:8], 1'b0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int s_addr_at(input int p);
        int h, v;
        h = p % S_HT;
        v = (p / S_HT) % S_VT;
        if (v >= S_VA) return S_VA * S_HA - 1;
        if (h >= S_HA) return v * S_HA + S_HA - 1;
        return v * S_HA + h;
    endfunction

    // Counters sit at position ks after ks edges; syncs and colour show position ks-2.
    task automatic check_small(input int ks_i, input logic en_p);
        int p, h, v, a;
        logic [11:0] rgb_e;
        logic hs_e, vs_e;
        p = ks_i - 2;
        hs_e = 1'b1;
        vs_e = 1'b1;
        rgb_e = 12'h0;
        if (p >= 0) begin
            h = p % S_HT;
            v = (p / S_HT) % S_VT;
            hs_e = !((h >= S_HA + S_HF) && (h < S_HA + S_HF + S_HS));
            vs_e = !((v >= S_VA + S_VF) && (v < S_VA + S_VF + S_VS));
            if (h < S_HA && v < S_VA && en_p) begin
                a = v * S_HA + h;
                rgb_e = {a[3:0], a[7:4], a[11:8]};
            end
        end
        check("s_addr", addr_s, s_addr_at(ks_i));
        check("s_hsync", hsync_s, hs_e);
        check("s_vsync", vsync_s, vs_e);
        check("s_rgb", rgb_s, rgb_e);
        check("s_frame_start", fs_s, ((ks_i - 1) % S_FRAME) == 0);
    endtask

    initial begin
        int ks, fall1, fall2, low_d, vs_low, vs_fall, rst_hold;
        logic hs_prev_d, vs_prev_s, en_prev_s, did_rst;
        ks = 0; fall1 = -1; fall2 = -1; low_d = 0; vs_low = 0; vs_fall = -1; rst_hold = 0;
        did_rst = 1'b0;
        rst = 1'b1; rst_s = 1'b1; en_d = 1'b1; en_s = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("d_rst_hsync", hsync_d, 1'b1);
        check("d_rst_vsync", vsync_d, 1'b1);
        check("d_rst_rgb", rgb_d, 12'h0);
        check("d_rst_fs", fs_d, 1'b0);
        check("d_rst_addr", addr_d, 20'd0);
        @(negedge clk);
        rst = 1'b0;
        rst_s = 1'b0;
        hs_prev_d = hsync_d;
        vs_prev_s = vsync_s;

        for (int k = 1; k <= 2400; k++) begin
            en_prev_s = en_s;
            tick();
            if (k == 1) begin
                check("d_fs_first_edge", fs_d, 1'b1);
                check("d_rgb_k1", rgb_d, 12'h0);
            end
            if (k == 2) begin
                check("d_fs_one_cycle", fs_d, 1'b0);
                check("d_rgb_px_0_0", rgb_d, 12'hF0F);
            end
            if (k == 639)  check("d_addr_639_0", addr_d, 20'd639);
            if (k == 641)  check("d_rgb_px_639_0", rgb_d, 12'hF0F);
            if (k == 642)  check("d_rgb_hblank", rgb_d, 12'h0);
            if (k == 700)  check("d_addr_hold_blank", addr_d, 20'd639);
            if (k == 800)  check("d_addr_0_1", addr_d, 20'd640);
            if (k == 802)  check("d_rgb_px_0_1", rgb_d, 12'hF0F);
            if (k == 820)  en_d = 1'b0;
            if (k == 900)  check("d_rgb_en_off", rgb_d, 12'h0);
            if (k == 1000) en_d = 1'b1;
            if (k == 1100) check("d_rgb_en_on", rgb_d, 12'hF0F);
            if (k == 1439) check("d_addr_639_1", addr_d, 20'd1279);
            if (k == 1700) check("d_vsync_high", vsync_d, 1'b1);
            if (hs_prev_d && !hsync_d) begin
                if (fall1 < 0) fall1 = k;
                else if (fall2 < 0) fall2 = k;
            end
            if (k <= 800 && !hsync_d) low_d++;
            hs_prev_d = hsync_d;

            if (rst_hold > 0) begin
                check("s_rst_hold_addr", addr_s, 20'd0);
                check("s_rst_hold_rgb", rgb_s, 12'h0);
                check("s_rst_hold_fs", fs_s, 1'b0);
                rst_hold--;
                if (rst_hold == 0) begin
                    rst_s = 1'b0;
                    ks = 0;
                end
            end else begin
                ks++;
                check_small(ks, en_prev_s);
                if (!did_rst && ks <= S_FRAME) begin
                    if (!vsync_s) vs_low++;
                    if (vs_prev_s && !vsync_s && vs_fall < 0) vs_fall = ks;
                end
                vs_prev_s = vsync_s;
                if (!did_rst && ks == S_FRAME + 4 * S_HT) en_s = 1'b0;
                if (!did_rst && ks == S_FRAME + 9 * S_HT) en_s = 1'b1;
                if (!did_rst && ks == 2 * S_FRAME + 10 * S_HT + 7) begin
                    check("s_pre_rst_addr", addr_s, 20'd167);
                    rst_s = 1'b1;
                    #1;
                    check("s_rst_async_addr", addr_s, 20'd0);
                    check("s_rst_async_rgb", rgb_s, 12'h0);
                    check("s_rst_async_hsync", hsync_s, 1'b1);
                    check("s_rst_async_vsync", vsync_s, 1'b1);
                    check("s_rst_async_fs", fs_s, 1'b0);
                    did_rst = 1'b1;
                    rst_hold = 2;
                    vs_prev_s = 1'b1;
                end
            end
        end

        check("d_hsync_fall", fall1, 658);
        check("d_hsync_width", low_d, 96);
        check("d_line_period", fall2 - fall1, 800);
        check("s_vsync_fall", vs_fall, 2 + (S_VA + S_VF) * S_HT);
        check("s_vsync_width", vs_low, S_VS * S_HT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
